// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types for the FFT frame sequencer: the complex sample format
// and the sequencer state encoding.
package fft_frame_ctrl_pkg;

  localparam int DATA_W = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } complex_product_t;

  typedef enum logic {
    LOAD = 1'b0,
    WAIT = 1'b1
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_frame_ctrl_watchdog.sv
// Generic latency watchdog: counts enabled cycles from zero and pulses
// o_expired on the cycle the count reaches LATENCY_MAX-1. A clear holds
// the count at zero, so the owner decides when a measurement window opens.
module fft_watchdog #(
  parameter int LATENCY_MAX = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int WD_W = (LATENCY_MAX > 2) ? $clog2(LATENCY_MAX) : 1;
  localparam logic [WD_W-1:0] LIMIT = WD_W'(LATENCY_MAX - 1);

  logic [WD_W-1:0] r_count;
  logic            w_atLimit;

  assign w_atLimit = (r_count == LIMIT);
  assign o_expired = i_enable & ~i_clear & w_atLimit;

  // Cycle counter for the open window; rolls back to zero after expiry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_atLimit ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of the radix-2 FFT: pairs two antenna streams,
// feeds exactly N pairs per frame, then waits for the FFT result while a
// watchdog guards the latency. Counts frames and flags protocol errors.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int N           = 32,
  parameter int LATENCY_MAX = 4 * N,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             clear_err,
  input  logic             s0_valid,
  input  complex_product_t s0_data,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  complex_product_t s1_data,
  output logic             s1_ready,
  output logic             fft_enable,
  output complex_product_t fft_data_0,
  output complex_product_t fft_data_1,
  input  logic             fft_out_valid,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_spurious
);

  localparam int SCW = $clog2(N);
  localparam logic [SCW-1:0] LAST_IDX = SCW'(N - 1);

  fft_ctrl_state_t  r_state;
  logic [SCW-1:0]   r_sampleCount;
  logic             r_fftEnable;
  complex_product_t r_fftData0;
  complex_product_t r_fftData1;
  logic             r_frameDone;
  logic [CNT_W-1:0] r_frameCount;
  logic             r_errTimeout;
  logic             r_errSpurious;

  logic w_loadOpen;
  logic w_xfer;
  logic w_expired;
  logic w_wdClear;
  logic w_wdEnable;
  logic w_setTimeout;
  logic w_setSpurious;

  // Both streams are consumed together or not at all; reset and flush
  // close the input so nothing is accepted while the sequencer is held.
  assign w_loadOpen = reset & (r_state == LOAD) & ~flush;
  assign w_xfer     = w_loadOpen & s0_valid & s1_valid;
  assign s0_ready   = w_loadOpen & s1_valid;
  assign s1_ready   = w_loadOpen & s0_valid;

  assign w_wdEnable = (r_state == WAIT);
  assign w_wdClear  = flush | (r_state != WAIT);

  assign w_setTimeout  = (r_state == WAIT) & ~flush & ~fft_out_valid & w_expired;
  assign w_setSpurious = (r_state == LOAD) & fft_out_valid;

  assign fft_enable   = r_fftEnable;
  assign fft_data_0   = r_fftData0;
  assign fft_data_1   = r_fftData1;
  assign frame_done   = r_frameDone;
  assign frame_count  = r_frameCount;
  assign busy         = (r_state == WAIT);
  assign err_timeout  = r_errTimeout;
  assign err_spurious = r_errSpurious;

  fft_watchdog #(
    .LATENCY_MAX(LATENCY_MAX)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_wdClear),
    .i_enable (w_wdEnable),
    .o_expired(w_expired)
  );

  // Frame sequencing FSM with registered FFT drive and completion outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= LOAD;
      r_sampleCount <= '0;
      r_fftEnable   <= 1'b0;
      r_fftData0    <= '0;
      r_fftData1    <= '0;
      r_frameDone   <= 1'b0;
      r_frameCount  <= '0;
    end else begin
      r_fftEnable <= w_xfer;
      r_frameDone <= 1'b0;
      if (w_xfer) begin
        r_fftData0 <= s0_data;
        r_fftData1 <= s1_data;
      end
      if (flush) begin
        r_state       <= LOAD;
        r_sampleCount <= '0;
      end else begin
        case (r_state)
          LOAD: begin
            if (w_xfer) begin
              if (r_sampleCount == LAST_IDX) begin
                r_sampleCount <= '0;
                r_state       <= WAIT;
              end else begin
                r_sampleCount <= r_sampleCount + 1'b1;
              end
            end
          end
          WAIT: begin
            if (fft_out_valid) begin
              r_state      <= LOAD;
              r_frameDone  <= 1'b1;
              r_frameCount <= r_frameCount + 1'b1;
            end else if (w_expired) begin
              r_state <= LOAD;
            end
          end
          default: r_state <= LOAD;
        endcase
      end
    end
  end

  // Sticky error flags; a new error event outranks a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_errTimeout  <= 1'b0;
      r_errSpurious <= 1'b0;
    end else begin
      r_errTimeout  <= w_setTimeout  | (r_errTimeout  & ~clear_err);
      r_errSpurious <= w_setSpurious | (r_errSpurious & ~clear_err);
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for the FFT frame sequencer: N=32, LATENCY_MAX=128 and a
// 4-bit frame counter so the wrap is reachable quickly.
module tb_fft_frame_ctrl;
  import fft_frame_ctrl_pkg::*;

  localparam int N   = 32;
  localparam int LAT = 128;
  localparam int CW  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             clear_err;
  logic             s0_valid;
  logic             s1_valid;
  logic             fft_out_valid;
  complex_product_t s0_data;
  complex_product_t s1_data;
  complex_product_t fft_data_0;
  complex_product_t fft_data_1;
  logic             s0_ready;
  logic             s1_ready;
  logic             fft_enable;
  logic             frame_done;
  logic             busy;
  logic             err_timeout;
  logic             err_spurious;
  logic [CW-1:0]    frame_count;

  int checks   = 0;
  int failures = 0;

  fft_frame_ctrl #(
    .N(N),
    .LATENCY_MAX(LAT),
    .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .clear_err    (clear_err),
    .s0_valid     (s0_valid),
    .s0_data      (s0_data),
    .s0_ready     (s0_ready),
    .s1_valid     (s1_valid),
    .s1_data      (s1_data),
    .s1_ready     (s1_ready),
    .fft_enable   (fft_enable),
    .fft_data_0   (fft_data_0),
    .fft_data_1   (fft_data_1),
    .fft_out_valid(fft_out_valid),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL sim_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic complex_product_t mk(input int re, input int im);
    complex_product_t c;
    c.re = re[DATA_W-1:0];
    c.im = im[DATA_W-1:0];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setPair(input int k);
    s0_data  = mk(k, -k);
    s1_data  = mk(2 * k, 0);
    s0_valid = 1'b1;
    s1_valid = 1'b1;
  endtask

  task automatic idleInputs();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic doReset();
    reset         = 1'b0;
    flush         = 1'b0;
    clear_err     = 1'b0;
    fft_out_valid = 1'b0;
    s0_data       = mk(0, 0);
    s1_data       = mk(0, 0);
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic loadFrame();
    for (int k = 0; k < N; k++) begin
      setPair(k);
      tick();
    end
    idleInputs();
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    flush         = 1'b0;
    clear_err     = 1'b0;
    fft_out_valid = 1'b0;
    s0_data       = mk(7, 7);
    s1_data       = mk(9, 9);
    s0_valid      = 1'b1;
    s1_valid      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({fft_enable, s0_ready, s1_ready, busy, frame_done, err_timeout, err_spurious} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=0000000",
               {fft_enable, s0_ready, s1_ready, busy, frame_done, err_timeout, err_spurious});
    end
    checks++;
    if (fft_data_0 !== mk(0, 0) || fft_data_1 !== mk(0, 0)) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h/%h exp=0/0", fft_data_0, fft_data_1);
    end
    checks++;
    if (frame_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_count got=%0d exp=0", frame_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({s0_ready, s1_ready} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL post_reset_ready got=%b exp=11", {s0_ready, s1_ready});
    end
    idleInputs();
  endtask

  task automatic test_full_frame();
    doReset();
    checks++;
    if (fft_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_pre_enable got=%b exp=0", fft_enable);
    end
    for (int k = 0; k < N; k++) begin
      setPair(k);
      #1;
      checks++;
      if ({s0_ready, s1_ready} !== 2'b11) begin
        failures++;
        $display("[TB] FAIL full_ready k=%0d got=%b exp=11", k, {s0_ready, s1_ready});
      end
      tick();
      checks++;
      if (fft_enable !== 1'b1 || fft_data_0 !== mk(k, -k) || fft_data_1 !== mk(2 * k, 0)) begin
        failures++;
        $display("[TB] FAIL full_pair k=%0d got=%b %h %h exp=1 %h %h", k, fft_enable,
                 fft_data_0, fft_data_1, mk(k, -k), mk(2 * k, 0));
      end
    end
    #1;
    checks++;
    if ({s0_ready, s1_ready, busy} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL full_wait_ready got=%b exp=001", {s0_ready, s1_ready, busy});
    end
    tick();
    checks++;
    if (fft_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_post_enable got=%b exp=0", fft_enable);
    end
    idleInputs();
  endtask

  task automatic test_stall();
    doReset();
    for (int k = 0; k < N; k++) begin
      if (k == 10) begin
        repeat (3) begin
          s0_data  = mk(10, -10);
          s0_valid = 1'b1;
          s1_valid = 1'b0;
          #1;
          checks++;
          if (s0_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_s0_ready got=%b exp=0", s0_ready);
          end
          tick();
          checks++;
          if (fft_enable !== 1'b0 || fft_data_0 !== mk(9, -9)) begin
            failures++;
            $display("[TB] FAIL stall_gap got=%b %h exp=0 %h", fft_enable, fft_data_0, mk(9, -9));
          end
        end
      end
      setPair(k);
      tick();
      checks++;
      if (fft_enable !== 1'b1 || fft_data_0 !== mk(k, -k) || fft_data_1 !== mk(2 * k, 0)) begin
        failures++;
        $display("[TB] FAIL stall_pair k=%0d got=%b %h %h exp=1 %h %h", k, fft_enable,
                 fft_data_0, fft_data_1, mk(k, -k), mk(2 * k, 0));
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_busy got=%b exp=1", busy);
    end
    idleInputs();
  endtask

  task automatic test_completion();
    doReset();
    loadFrame();
    repeat (20) tick();
    fft_out_valid = 1'b1;
    tick();
    checks++;
    if ({frame_done, busy} !== 2'b10 || frame_count !== 4'd1) begin
      failures++;
      $display("[TB] FAIL done_pulse got=%b cnt=%0d exp=10 cnt=1", {frame_done, busy}, frame_count);
    end
    repeat (3) begin
      tick();
      checks++;
      if (frame_done !== 1'b0 || frame_count !== 4'd1) begin
        failures++;
        $display("[TB] FAIL done_single got=%b cnt=%0d exp=0 cnt=1", frame_done, frame_count);
      end
    end
    fft_out_valid = 1'b0;
    setPair(0);
    #1;
    checks++;
    if ({s0_ready, s1_ready} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL done_resume got=%b exp=11", {s0_ready, s1_ready});
    end
    idleInputs();
  endtask

  task automatic test_timeout();
    doReset();
    loadFrame();
    for (int i = 1; i < LAT; i++) begin
      tick();
      checks++;
      if ({err_timeout, busy} !== 2'b01) begin
        failures++;
        $display("[TB] FAIL timeout_early i=%0d got=%b exp=01", i, {err_timeout, busy});
      end
    end
    tick();
    checks++;
    if ({err_timeout, busy, frame_done} !== 3'b100 || frame_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL timeout_fire got=%b cnt=%0d exp=100 cnt=0",
               {err_timeout, busy, frame_done}, frame_count);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_clear got=%b exp=0", err_timeout);
    end
  endtask

  task automatic test_expiry_race();
    doReset();
    loadFrame();
    repeat (LAT - 1) tick();
    fft_out_valid = 1'b1;
    tick();
    fft_out_valid = 1'b0;
    checks++;
    if ({frame_done, err_timeout, busy} !== 3'b100 || frame_count !== 4'd1) begin
      failures++;
      $display("[TB] FAIL race got=%b cnt=%0d exp=100 cnt=1",
               {frame_done, err_timeout, busy}, frame_count);
    end
  endtask

  task automatic test_flush();
    doReset();
    for (int k = 0; k < 15; k++) begin
      setPair(k);
      tick();
    end
    setPair(15);
    flush = 1'b1;
    #1;
    checks++;
    if ({s0_ready, s1_ready} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL flush_ready got=%b exp=00", {s0_ready, s1_ready});
    end
    tick();
    flush = 1'b0;
    checks++;
    if (fft_enable !== 1'b0 || fft_data_0 !== mk(14, -14)) begin
      failures++;
      $display("[TB] FAIL flush_enable got=%b %h exp=0 %h", fft_enable, fft_data_0, mk(14, -14));
    end
    for (int k = 0; k < N - 1; k++) begin
      setPair(k);
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_31_pairs got=%b exp=0", busy);
    end
    setPair(N - 1);
    tick();
    idleInputs();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_32_pairs got=%b exp=1", busy);
    end
    fft_out_valid = 1'b1;
    flush         = 1'b1;
    tick();
    fft_out_valid = 1'b0;
    flush         = 1'b0;
    checks++;
    if ({frame_done, busy} !== 2'b00 || frame_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL flush_priority got=%b cnt=%0d exp=00 cnt=0", {frame_done, busy}, frame_count);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    for (int k = 0; k < 7; k++) begin
      setPair(k);
      tick();
    end
    setPair(7);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({fft_enable, s0_ready, s1_ready, busy} !== 4'b0 ||
        fft_data_0 !== mk(0, 0) || fft_data_1 !== mk(0, 0)) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b %h %h exp=0000 0 0",
               {fft_enable, s0_ready, s1_ready, busy}, fft_data_0, fft_data_1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < N - 1; k++) begin
      setPair(k);
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_partial got=%b exp=0", busy);
    end
    setPair(N - 1);
    tick();
    idleInputs();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_full got=%b exp=1", busy);
    end
  endtask

  task automatic test_spurious();
    doReset();
    fft_out_valid = 1'b1;
    clear_err     = 1'b1;
    tick();
    fft_out_valid = 1'b0;
    checks++;
    if (err_spurious !== 1'b1) begin
      failures++;
      $display("[TB] FAIL spur_set_wins got=%b exp=1", err_spurious);
    end
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_spurious !== 1'b0) begin
      failures++;
      $display("[TB] FAIL spur_clear got=%b exp=0", err_spurious);
    end
    for (int k = 0; k < 5; k++) begin
      setPair(k);
      tick();
    end
    setPair(5);
    fft_out_valid = 1'b1;
    tick();
    fft_out_valid = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || fft_enable !== 1'b1 || fft_data_0 !== mk(5, -5)) begin
      failures++;
      $display("[TB] FAIL spur_in_load got=%b %b %h exp=1 1 %h", err_spurious, fft_enable,
               fft_data_0, mk(5, -5));
    end
    for (int k = 6; k < N; k++) begin
      setPair(k);
      tick();
    end
    idleInputs();
    checks++;
    if ({busy, err_spurious, frame_done} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL spur_sequence got=%b exp=110", {busy, err_spurious, frame_done});
    end
  endtask

  task automatic test_wrap();
    doReset();
    for (int f = 0; f < 16; f++) begin
      loadFrame();
      fft_out_valid = 1'b1;
      tick();
      fft_out_valid = 1'b0;
      checks++;
      if (frame_done !== 1'b1 || frame_count !== 4'((f + 1) % 16)) begin
        failures++;
        $display("[TB] FAIL wrap f=%0d got=%b cnt=%0d exp=1 cnt=%0d", f, frame_done,
                 frame_count, (f + 1) % 16);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_completion();
    test_timeout();
    test_expiry_race();
    test_flush();
    test_async_reset();
    test_spurious();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
